// File: rtl/voice_allocator_if.sv
// Event handshake bundle for voice_allocator: a 24-bit MIDI message with valid/ready.
// The source (master) holds event_in and event_valid_in until event_ready_out is seen high.
interface voice_allocator_if;
    logic [23:0] event_in;
    logic        event_valid_in;
    logic        event_ready_out;

    modport master (output event_in, output event_valid_in, input event_ready_out);
    modport slave  (input event_in, input event_valid_in, output event_ready_out);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans the voices one per cycle, then commits a NOTE_ON/NOTE_OFF
// (retrigger > free > oldest-steal). Optional sustain pedal behaviour under `SUSTAIN_PEDAL_EN.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    voice_allocator_if.slave        evt,
    output logic [NUM_VOICES*8-1:0] voice_pitch_out,
    output logic [NUM_VOICES*8-1:0] voice_vel_out,
    output logic [NUM_VOICES-1:0]   voice_gate_out,
    output logic [NUM_VOICES-1:0]   voice_trig_out,
    output logic                    steal_out
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_pitch [NUM_VOICES];
    logic [7:0]          r_vel   [NUM_VOICES];
    logic [AGE_BITS-1:0] r_age   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate, r_trig;
    logic                r_steal;

    // Event latched at acceptance plus the running scan results.
    logic                r_is_on;
    logic [7:0]          r_note, r_evt_vel;
    logic [IDX_W-1:0]    r_idx, r_match_idx, r_free_idx, r_old_idx;
    logic                r_match_vld, r_free_vld, r_old_vld;
    logic [AGE_BITS-1:0] r_old_age;

    logic [7:0]          w_status, w_d1, w_d2;
    logic                w_accept, w_note_on, w_note_off, w_all_off, w_free_cand, w_steal;
    logic [IDX_W-1:0]    w_target;

`ifdef SUSTAIN_PEDAL_EN
    logic                r_pedal;
    logic [NUM_VOICES-1:0] r_sus;
    logic                w_pedal_cc;
    assign w_pedal_cc  = (w_status == 8'hB0) && (w_d1 == 8'h40);
    assign w_free_cand = !r_gate[r_idx] || r_sus[r_idx];
`else
    assign w_free_cand = !r_gate[r_idx];
`endif

    assign w_status   = evt.event_in[23:16];
    assign w_d1       = evt.event_in[15:8];
    assign w_d2       = evt.event_in[7:0];
    assign w_accept   = evt.event_valid_in && (r_state == S_IDLE);
    // A NOTE_ON below note 12 has no phase-table entry and is swallowed.
    assign w_note_on  = (w_status == 8'h90) && (w_d2 != 8'd0) && (w_d1 >= 8'd12);
    assign w_note_off = (w_status == 8'h80) || ((w_status == 8'h90) && (w_d2 == 8'd0));
    assign w_all_off  = (w_status == 8'hB0) && (w_d1 == 8'h7B);

    assign evt.event_ready_out = (r_state == S_IDLE);
    assign voice_gate_out      = r_gate;
    assign voice_trig_out      = r_trig;
    assign steal_out           = r_steal;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
        assign voice_pitch_out[8*gi +: 8] = r_pitch[gi];
        assign voice_vel_out[8*gi +: 8]   = r_vel[gi];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && (w_note_on || w_note_off)) w_state_nxt = S_SCAN;
            S_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_target = r_old_idx;
        w_steal  = 1'b0;
        if (r_match_vld)     w_target = r_match_idx;
        else if (r_free_vld) w_target = r_free_idx;
        else                 w_steal  = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_is_on     <= 1'b0;
            r_note      <= '0;
            r_evt_vel   <= '0;
            r_idx       <= '0;
            r_match_idx <= '0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
            r_old_vld   <= 1'b0;
            r_old_age   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept && (w_note_on || w_note_off)) begin
                    r_is_on     <= w_note_on;
                    r_note      <= w_d1;
                    r_evt_vel   <= w_d2;
                    r_idx       <= '0;
                    r_match_vld <= 1'b0;
                    r_free_vld  <= 1'b0;
                    r_old_vld   <= 1'b0;
                end
                S_SCAN: begin
                    if (!r_match_vld && (r_pitch[r_idx] == r_note)) begin
                        r_match_vld <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                    if (!r_free_vld && w_free_cand) begin
                        r_free_vld <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (r_gate[r_idx] && (!r_old_vld || (r_age[r_idx] > r_old_age))) begin
                        r_old_vld <= 1'b1;
                        r_old_idx <= r_idx;
                        r_old_age <= r_age[r_idx];
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the per-voice arrays are small register files, so they take the async reset; a
    // reset mid-event must leave no stale voice behind.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_pitch[i] <= '0;
                r_vel[i]   <= '0;
                r_age[i]   <= '0;
            end
            r_gate  <= '0;
            r_trig  <= '0;
            r_steal <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
            r_pedal <= 1'b0;
            r_sus   <= '0;
`endif
        end else begin
            r_trig  <= '0;
            r_steal <= 1'b0;
            if (w_accept && w_all_off) begin
                r_gate <= '0;
                for (int i = 0; i < NUM_VOICES; i++) r_pitch[i] <= '0;
`ifdef SUSTAIN_PEDAL_EN
                r_sus <= '0;
`endif
            end
`ifdef SUSTAIN_PEDAL_EN
            if (w_accept && w_pedal_cc) begin
                r_pedal <= (w_d2 >= 8'd64);
                if (w_d2 < 8'd64) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (r_sus[i]) begin
                            r_gate[i]  <= 1'b0;
                            r_pitch[i] <= '0;
                        end
                    end
                    r_sus <= '0;
                end
            end
`endif
            if (r_state == S_COMMIT) begin
                if (r_is_on) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == w_target) begin
                            r_pitch[i] <= r_note;
                            r_vel[i]   <= r_evt_vel;
                            r_gate[i]  <= 1'b1;
                            r_age[i]   <= '0;
`ifdef SUSTAIN_PEDAL_EN
                            r_sus[i]   <= 1'b0;
`endif
                        end else if (r_gate[i] && (r_age[i] != AGE_MAX)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                    r_trig[w_target] <= 1'b1;
                    r_steal          <= w_steal;
                end else if (r_match_vld) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (r_pedal) r_sus[r_match_idx] <= 1'b1;
                    else
`endif
                    begin
                        r_gate[r_match_idx]  <= 1'b0;
                        r_pitch[r_match_idx] <= '0;
                        r_vel[r_match_idx]   <= r_evt_vel;
                    end
                end
            end
        end
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of synth voices scheduled; legal range 2..8.
REQ-002 Parameter AGE_BITS, default 8, width of each per-voice age counter.
REQ-003 Port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst_n_in  input  1  asynchronous active-low reset; assertion clears state immediately; deassertion is synchronous to clk_in.
REQ-005 Port event_in  input  24  MIDI message: [23:16] status, [15:8] data1, [7:0] data2.
REQ-006 Port event_valid_in  input  1  event_in valid this cycle.
REQ-007 Port event_ready_out  output  1  block accepts an event this cycle; handshake completes when valid and ready are both high.
REQ-008 Port voice_pitch_out  output  NUM_VOICES*8  per-voice MIDI note; voice i occupies bits [8i+7:8i]; 0 means silent.
REQ-009 Port voice_vel_out  output  NUM_VOICES*8  per-voice velocity, same packing.
REQ-010 Port voice_gate_out  output  NUM_VOICES  per-voice gate; 1 means key held.
REQ-011 Port voice_trig_out  output  NUM_VOICES  one-cycle pulse on the voice just (re)assigned, for envelope restart.
REQ-012 Port steal_out  output  1  one-cycle pulse when a NOTE_ON stole a gated voice.

Function
REQ-013 Only channel 0 is decoded: 0x90 NOTE_ON, 0x80 NOTE_OFF, 0xB0 CC; all other status bytes are accepted and dropped without state change.
REQ-014 NOTE_ON with data2 == 0 is treated as NOTE_OFF; NOTE_ON with data1 < 12 is dropped, because the phase table starts at note 12.
REQ-015 FSM states: IDLE, SCAN, COMMIT; event_ready_out is high only in IDLE.
REQ-016 IDLE: an accepted NOTE_ON or NOTE_OFF moves to SCAN; other accepted events stay in IDLE.
REQ-017 SCAN: examines one voice per cycle, index 0 to NUM_VOICES-1, for exactly NUM_VOICES cycles, then moves to COMMIT.
REQ-018 SCAN records the first voice whose pitch equals data1 (match), the lowest-index voice with gate 0 (free), and the gated voice with the largest age, ties going to the lowest index (oldest).
REQ-019 COMMIT, NOTE_ON target selection, in priority order: match (retrigger), free, oldest; when oldest is used, steal_out pulses.
REQ-020 COMMIT, NOTE_ON: target pitch is set to data1, velocity to data2, gate to 1, age to 0, and voice_trig_out[target] pulses; every other gated voice's age increments, saturating at 2^AGE_BITS-1.
REQ-021 COMMIT, NOTE_OFF: a matching voice has its gate cleared, pitch set to 0, and velocity set to data2; with no match, there is no change.
REQ-022 COMMIT always returns to IDLE; the latency from acceptance at cycle T to outputs visible is T+NUM_VOICES+2.
REQ-023 CC 0x7B (all notes off), accepted in IDLE, clears every gate and pitch on the next edge.
REQ-024 Pulse outputs are high for exactly the one cycle following COMMIT.
REQ-025 event_valid_in while busy is not consumed; the source holds event_in until ready.

Reset
REQ-026 On rst_n_in low: the FSM is in IDLE, every pitch, velocity, gate and age is 0, pulses are 0, and event_ready_out is 1 after deassertion.
REQ-027 Reset mid-SCAN or mid-COMMIT aborts the event; no partial voice update survives.

Configuration
REQ-028 Macro SUSTAIN_PEDAL_EN defined: CC 0x40 data2 >= 64 sets sustain, and data2 < 64 clears it.
REQ-029 With SUSTAIN_PEDAL_EN defined: while sustain is set, a matched NOTE_OFF marks the voice sustained, and its gate and pitch stay unchanged.
REQ-030 With SUSTAIN_PEDAL_EN defined: clearing sustain drops the gate and pitch of all sustained voices in one cycle.
REQ-031 With SUSTAIN_PEDAL_EN defined: sustained voices count as free for allocation.
REQ-032 Macro SUSTAIN_PEDAL_EN undefined: CC 0x40 is dropped, and no sustain state is built.

Verification
REQ-033 Scenario: NOTE_ON 0x903C64 after reset -> voice 0 pitch 0x3C, vel 0x64, gate 1, trig[0] pulse, 6 cycles after accept (NUM_VOICES=4).
REQ-034 Scenario: NOTE_ON notes 60, 62, 64, 65, 67 in sequence -> voices 0-3 take 60-65; note 67 steals voice 0 (oldest) and steal_out pulses once.
REQ-035 Scenario: NOTE_ON 60 twice -> the second retriggers voice 0, trig[0] pulses, and no other voice is gated.
REQ-036 Scenario: NOTE_ON 60, then 0x903C00 -> voice 0 gate 0, pitch 0; NOTE_OFF 61 afterwards -> no change.
REQ-037 Scenario: rst_n_in low during SCAN of NOTE_ON 60 -> all outputs 0 immediately, and after release voice 0 pitch remains 0.
REQ-038 Scenario (SUSTAIN_PEDAL_EN): 0xB0407F, NOTE_ON 60, NOTE_OFF 60 -> gate stays 1; 0xB04000 -> gate 0, pitch 0.
